// File: rtl/ram_ctrl_master.sv
// Purpose : command-side initiator for ram_ctrl; turns one valid/ready command into a single-cycle strobe and a registered response.
// Latency : write -> rsp_valid 2 cycles after accept; read -> rsp_valid p_rd_lat+2 cycles after accept.
// Backpres: one command in flight; cmd_ready low while busy, RESP holds rsp_* stable until rsp_ready.
//
// Ports:
//   clk, rst                 rising-edge clock, async active-high reset
//   cmd_valid/ready/we/op_code/addr/wdata   upstream command handshake
//   mem_en/we/re/op_code/addr/wdata, mem_rdata   ram_ctrl side
//   rsp_valid/ready/we/data  registered response handshake
//   busy                     state machine not idle
//   txn_cnt                  completed responses, wraps silently
module ram_ctrl_master #(
    parameter int p_mem_size = 8,
    parameter int p_rd_lat   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [1:0]            cmd_op_code,
    input  logic [p_mem_size-1:0] cmd_addr,
    input  logic [31:0]           cmd_wdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic [1:0]            mem_op_code,
    output logic [p_mem_size-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_we,
    output logic [31:0]           rsp_data,
    output logic                  busy,
    output logic [15:0]           txn_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [3:0] RD_LAT = 4'(p_rd_lat);

    state_t     state;
    state_t     state_nxt;
    logic       lat_we;
    logic [3:0] wait_cnt;
    logic       accept;
    logic       rsp_fire;

    assign accept   = (state == IDLE) && cmd_valid;
    assign rsp_fire = (state == RESP) && rsp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                // Gated by rst so the handshake reads 0 while reset is held.
                cmd_ready = ~rst;
                busy      = 1'b0;
                if (cmd_valid) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                mem_en    = 1'b1;
                mem_we    = lat_we;
                mem_re    = ~lat_we;
                state_nxt = lat_we ? RESP : WAIT;
            end
            WAIT: begin
                if (wait_cnt == 4'd1) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The mem_* address/data registers double as the command latches: they
    // load on acceptance and then hold until the next command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_we      <= 1'b0;
            mem_op_code <= 2'b00;
            mem_addr    <= '0;
            mem_wdata   <= 32'd0;
            wait_cnt    <= 4'd0;
            rsp_data    <= 32'd0;
            txn_cnt     <= 16'd0;
        end else begin
            if (accept) begin
                lat_we      <= cmd_we;
                mem_op_code <= cmd_op_code;
                mem_addr    <= cmd_addr;
                mem_wdata   <= cmd_wdata;
                // Writes respond with zero data; reads overwrite this in WAIT.
                rsp_data    <= 32'd0;
            end
            if (state == ISSUE && !lat_we) begin
                wait_cnt <= RD_LAT;
            end
            if (state == WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
                if (wait_cnt == 4'd1) begin
                    rsp_data <= mem_rdata;
                end
            end
            if (rsp_fire) begin
                txn_cnt <= txn_cnt + 16'd1;
            end
        end
    end

    assign rsp_we = lat_we;

endmodule

// File: tb/tb_ram_ctrl_master.sv
// Purpose : self-checking bench for ram_ctrl_master with a ram_ctrl memory model and response scoreboard.
// Latency : two DUTs (read latency 1 and 3) share one memory model; sel3 picks which one is driven.
// Backpres: the bench stalls rsp_ready and offers commands during stalls.
module tb_ram_ctrl_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel3;
    logic        cmd_valid;
    logic        cmd_we;
    logic [1:0]  cmd_op_code;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_ready;

    always #5 clk = ~clk;

    logic        cmd_ready1, mem_en1, mem_we1, mem_re1, rsp_valid1, rsp_we1, busy1;
    logic [1:0]  mem_op1;
    logic [7:0]  mem_addr1;
    logic [31:0] mem_wdata1, rsp_data1;
    logic [15:0] txn_cnt1;
    logic        cmd_ready3, mem_en3, mem_we3, mem_re3, rsp_valid3, rsp_we3, busy3;
    logic [1:0]  mem_op3;
    logic [7:0]  mem_addr3;
    logic [31:0] mem_wdata3, rsp_data3;
    logic [15:0] txn_cnt3;
    logic [31:0] rd_pipe [3];

    ram_ctrl_master #(.p_mem_size(8), .p_rd_lat(1)) dut1 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid & ~sel3), .cmd_ready(cmd_ready1), .cmd_we(cmd_we),
        .cmd_op_code(cmd_op_code), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_re(mem_re1), .mem_op_code(mem_op1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(rd_pipe[0]),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready & ~sel3), .rsp_we(rsp_we1),
        .rsp_data(rsp_data1), .busy(busy1), .txn_cnt(txn_cnt1)
    );

    ram_ctrl_master #(.p_mem_size(8), .p_rd_lat(3)) dut3 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid & sel3), .cmd_ready(cmd_ready3), .cmd_we(cmd_we),
        .cmd_op_code(cmd_op_code), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_re(mem_re3), .mem_op_code(mem_op3),
        .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rdata(rd_pipe[2]),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready & sel3), .rsp_we(rsp_we3),
        .rsp_data(rsp_data3), .busy(busy3), .txn_cnt(txn_cnt3)
    );

    // Outputs of whichever DUT is currently selected.
    logic        o_cmd_ready, o_mem_en, o_mem_we, o_mem_re, o_rsp_valid, o_rsp_we, o_busy;
    logic [1:0]  o_mem_op;
    logic [7:0]  o_mem_addr;
    logic [31:0] o_mem_wdata, o_rsp_data;
    logic [15:0] o_txn_cnt;
    assign o_cmd_ready = sel3 ? cmd_ready3 : cmd_ready1;
    assign o_mem_en    = sel3 ? mem_en3    : mem_en1;
    assign o_mem_we    = sel3 ? mem_we3    : mem_we1;
    assign o_mem_re    = sel3 ? mem_re3    : mem_re1;
    assign o_mem_op    = sel3 ? mem_op3    : mem_op1;
    assign o_mem_addr  = sel3 ? mem_addr3  : mem_addr1;
    assign o_mem_wdata = sel3 ? mem_wdata3 : mem_wdata1;
    assign o_rsp_valid = sel3 ? rsp_valid3 : rsp_valid1;
    assign o_rsp_we    = sel3 ? rsp_we3    : rsp_we1;
    assign o_rsp_data  = sel3 ? rsp_data3  : rsp_data1;
    assign o_busy      = sel3 ? busy3      : busy1;
    assign o_txn_cnt   = sel3 ? txn_cnt3   : txn_cnt1;

    // ram_ctrl model: write on strobe, read data shifted through a 3-deep pipe
    // so latency-1 and latency-3 masters tap stage 0 and stage 2.
    logic [31:0] ram [256];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) ram[i] <= 32'd0;
        end else if (o_mem_en && o_mem_we) begin
            ram[o_mem_addr] <= o_mem_wdata;
        end
        rd_pipe[0] <= (o_mem_en && o_mem_re) ? ram[o_mem_addr] : 32'hBAD0_BAD0;
        rd_pipe[1] <= rd_pipe[0];
        rd_pipe[2] <= rd_pipe[1];
    end

    typedef struct packed {
        logic        we;
        logic [31:0] data;
    } rsp_t;

    rsp_t        sb_q [$];
    logic [31:0] exp_mem [256];
    logic [15:0] exp_cnt [2];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 256; i++) exp_mem[i] = 32'd0;
        exp_cnt[0] = 16'd0;
        exp_cnt[1] = 16'd0;
        sb_q.delete();
    endtask

    task automatic run_cmd(input logic we, input logic [1:0] op, input logic [7:0] addr,
                           input logic [31:0] wd, input int stall, input logic poke_ready,
                           input logic poke_cmd);
        int   lat;
        int   n;
        int   idx;
        rsp_t e;
        lat = sel3 ? 3 : 1;
        idx = sel3 ? 1 : 0;
        @(negedge clk);
        cmd_valid   = 1'b1;
        cmd_we      = we;
        cmd_op_code = op;
        cmd_addr    = addr;
        cmd_wdata   = wd;
        n = 0;
        while (!o_cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!o_cmd_ready) check("cmd_ready_timeout", 32'(o_cmd_ready), 32'd1);
        // Accepted at the coming edge; scramble inputs to prove they were latched.
        @(negedge clk);
        cmd_valid   = 1'b0;
        cmd_addr    = ~addr;
        cmd_wdata   = $urandom;
        cmd_op_code = ~op;
        check("issue_en",    32'(o_mem_en), 32'd1);
        check("issue_we",    32'(o_mem_we), 32'(we));
        check("issue_re",    32'(o_mem_re), 32'(!we));
        check("issue_addr",  32'(o_mem_addr), 32'(addr));
        check("issue_op",    32'(o_mem_op), 32'(op));
        check("issue_wdata", o_mem_wdata, wd);
        check("issue_busy",  32'(o_busy), 32'd1);
        if (we) begin
            e.we = 1'b1;
            e.data = 32'd0;
            exp_mem[addr] = wd;
        end else begin
            e.we = 1'b0;
            e.data = exp_mem[addr];
        end
        sb_q.push_back(e);
        n = 1;
        while (!o_rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
            if (!o_rsp_valid) begin
                check("idle_strobes", {29'd0, o_mem_en, o_mem_we, o_mem_re}, 32'd0);
                if (poke_ready) rsp_ready = 1'($urandom_range(0, 1));
            end
        end
        check("rsp_latency", 32'(n), we ? 32'd2 : 32'(2 + lat));
        rsp_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
            check("stall_valid", 32'(o_rsp_valid), 32'd1);
            check("stall_data",  o_rsp_data, sb_q[0].data);
            check("stall_we",    32'(o_rsp_we), 32'(sb_q[0].we));
            check("stall_ready", 32'(o_cmd_ready), 32'd0);
            if (poke_cmd) begin
                cmd_valid = 1'b1;
                cmd_we    = 1'b1;
                cmd_addr  = 8'h55;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        e = sb_q.pop_front();
        check("rsp_valid", 32'(o_rsp_valid), 32'd1);
        check("rsp_we",    32'(o_rsp_we), 32'(e.we));
        check("rsp_data",  o_rsp_data, e.data);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        exp_cnt[idx] = exp_cnt[idx] + 16'd1;
        check("txn_cnt",     32'(o_txn_cnt), 32'(exp_cnt[idx]));
        check("post_valid",  32'(o_rsp_valid), 32'd0);
        check("post_busy",   32'(o_busy), 32'd0);
        check("post_ready",  32'(o_cmd_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        sel3 = 1'b0;
        cmd_valid = 1'b0;
        cmd_we = 1'b0;
        cmd_op_code = 2'b00;
        cmd_addr = 8'h00;
        cmd_wdata = 32'd0;
        rsp_ready = 1'b0;
        clear_model();
        @(negedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready1), 32'd0);
        check("rst_strobes", {29'd0, mem_en1, mem_we1, mem_re1}, 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid1), 32'd0);
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_txn_cnt", 32'(txn_cnt1), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rel_cmd_ready", 32'(cmd_ready1), 32'd1);

        // Directed write, then reads at latency 1, then a backpressured read.
        run_cmd(1'b1, 2'b01, 8'h2A, 32'hDEAD_BEEF, 0, 1'b0, 1'b0);
        run_cmd(1'b0, 2'b01, 8'h2A, 32'h0, 0, 1'b0, 1'b0);
        check("read_2a_model", exp_mem[8'h2A], 32'hDEAD_BEEF);
        run_cmd(1'b0, 2'b11, 8'h2A, 32'h0, 10, 1'b0, 1'b1);

        // Reset in the middle of a read's WAIT cycle.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_we = 1'b0;
        cmd_addr = 8'h2A;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("mid_busy_before", 32'(busy1), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_cmd_ready", 32'(cmd_ready1), 32'd0);
        check("mid_strobes", {29'd0, mem_en1, mem_we1, mem_re1}, 32'd0);
        check("mid_mem_bus", {22'd0, mem_op1, mem_addr1}, 32'd0);
        check("mid_mem_wdata", mem_wdata1, 32'd0);
        check("mid_rsp", {30'd0, rsp_valid1, rsp_we1}, 32'd0);
        check("mid_rsp_data", rsp_data1, 32'd0);
        check("mid_busy", 32'(busy1), 32'd0);
        check("mid_txn_cnt", 32'(txn_cnt1), 32'd0);
        clear_model();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rel_ready", 32'(cmd_ready1), 32'd1);
        check("mid_rel_valid", 32'(rsp_valid1), 32'd0);
        check("mid_rel_cnt", 32'(txn_cnt1), 32'd0);

        // Latency-3 master.
        sel3 = 1'b1;
        run_cmd(1'b1, 2'b00, 8'h2A, 32'hDEAD_BEEF, 0, 1'b0, 1'b0);
        run_cmd(1'b0, 2'b10, 8'h2A, 32'h0, 2, 1'b0, 1'b0);
        sel3 = 1'b0;

        // Random stream against the memory model.
        for (int i = 0; i < 255; i++) begin
            run_cmd(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    8'($urandom_range(0, 15)), $urandom,
                    $urandom_range(0, 3), 1'b1, 1'($urandom_range(0, 1)));
        end
        check("txn_cnt_255", 32'(txn_cnt1), 32'd255);

        // Counter wrap: preload near the top, then complete three writes.
        @(negedge clk);
        force dut1.txn_cnt = 16'hFFFE;
        #1;
        release dut1.txn_cnt;
        exp_cnt[0] = 16'hFFFE;
        run_cmd(1'b1, 2'b00, 8'hFF, 32'h1234_5678, 0, 1'b0, 1'b0);
        run_cmd(1'b1, 2'b11, 8'h00, 32'h8765_4321, 0, 1'b0, 1'b0);
        check("wrap_zero", 32'(txn_cnt1), 32'h0000);
        run_cmd(1'b1, 2'b01, 8'h01, 32'hA5A5_5A5A, 0, 1'b0, 1'b0);
        check("wrap_one", 32'(txn_cnt1), 32'h0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
